// File: rtl/mod_rev_cnt_pkg.sv
// Shared encodings for the mod_rev_cnt reversible counter.
//   mode_e  : counting mode selected on the mode port (11 is reserved, counts as wrap)
//   state_e : one-shot controller states
package mod_rev_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: emits tick on every (div+1)-th cycle with en=1.
// Ports:
//   clk  - clock, rising edge
//   R    - synchronous active-high reset
//   clr  - synchronous phase clear (load / start of the parent counter)
//   en   - advance enable
//   div  - divide ratio minus one
//   tick - combinational, high on the enabled cycle that completes a period
module cnt_prescaler #(
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // Phase counter; restarts after every tick
    always_ff @(posedge clk) begin
        if (R || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/mod_rev_cnt.sv
// Loadable reversible counter with inclusive limit, wrap/saturate/one-shot
// modes and a registered terminal-count pulse.
// Optional feature macro: MOD_REV_CNT_PRESCALE_EN (adds pre_div and prescaler).
// Ports:
//   clk, R       - clock and synchronous active-high reset
//   en, rev      - count enable, direction (1 = down)
//   load, D      - load clamp(D) into Q
//   start        - one-shot start (ONESHOT mode only)
//   mode         - 00 wrap, 01 sat, 10 one-shot, 11 wrap
//   lim          - inclusive upper bound
//   Q, tc, busy  - registered count, terminal pulse, one-shot running flag
//   at_lim       - combinational Q == lim
//   pre_div      - prescale ratio (macro builds only)
module mod_rev_cnt
    import mod_rev_cnt_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             en,
    input  logic             rev,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     lim,
    input  logic [N-1:0]     D,
`ifdef MOD_REV_CNT_PRESCALE_EN
    input  logic [PRE_W-1:0] pre_div,
`endif
    output logic [N-1:0]     Q,
    output logic             tc,
    output logic             at_lim,
    output logic             busy
);

    if (PRE_W == 0) begin : g_bad_pre_w
        $error("mod_rev_cnt: PRE_W must be at least 1");
    end

    state_e       state;
    logic         ce;
    logic         oneshot;
    logic         start_acc;
    logic [N-1:0] clamp_d;
    logic [N-1:0] q_inc;
    logic [N-1:0] q_dec;
    logic [N-1:0] wrap_nxt;
    logic         wrap_tc;
    logic [N-1:0] step_nxt;
    logic         step_lands;
    logic         at_bound;

    assign oneshot   = (mode == MODE_ONESHOT);
    assign start_acc = oneshot && start && (state != ST_RUN);
    assign clamp_d   = (D > lim) ? lim : D;
    assign q_inc     = Q + N'(1);
    assign q_dec     = Q - N'(1);
    assign at_lim    = (Q == lim);

`ifdef MOD_REV_CNT_PRESCALE_EN
    logic pre_tick;

    cnt_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk  (clk),
        .R    (R),
        .clr  (load || start_acc),
        .en   (en),
        .div  (pre_div),
        .tick (pre_tick)
    );

    assign ce = en && pre_tick;
`else
    assign ce = en;
`endif

    // Next values for one step in wrap mode and in the bounded modes.
    // Q above lim (limit lowered underneath it) is treated as past the boundary.
    always_comb begin
        wrap_nxt   = q_inc;
        wrap_tc    = 1'b0;
        step_nxt   = Q;
        step_lands = 1'b0;
        at_bound   = 1'b0;
        if (rev) begin
            wrap_tc    = (Q == '0);
            wrap_nxt   = wrap_tc ? lim : q_dec;
            at_bound   = (Q == '0);
            step_nxt   = at_bound ? Q : q_dec;
            step_lands = !at_bound && (q_dec == '0);
        end else begin
            wrap_tc    = (Q >= lim);
            wrap_nxt   = wrap_tc ? '0 : q_inc;
            at_bound   = (Q == lim);
            step_nxt   = (Q > lim) ? lim : (at_bound ? Q : q_inc);
            step_lands = !at_bound && ((Q > lim) || (q_inc == lim));
        end
    end

    // Count register, terminal pulse and one-shot controller
    always_ff @(posedge clk) begin
        if (R) begin
            Q     <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
        end else begin
            tc <= 1'b0;
            if (!oneshot) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
            if (start_acc) begin
                Q     <= clamp_d;
                state <= ST_RUN;
                busy  <= 1'b1;
            end else if (load) begin
                Q <= clamp_d;
            end else if (ce) begin
                case (mode)
                    MODE_SAT: begin
                        Q  <= step_nxt;
                        tc <= step_lands;
                    end
                    MODE_ONESHOT: begin
                        if (state == ST_RUN) begin
                            Q <= step_nxt;
                            if (step_lands || at_bound) begin
                                tc    <= 1'b1;
                                state <= ST_DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        Q  <= wrap_nxt;
                        tc <= wrap_tc;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_rev_cnt.sv
// Directed self-checking bench for mod_rev_cnt (N=4).
module tb_mod_rev_cnt;

    localparam int unsigned N     = 4;
    localparam int unsigned PRE_W = 4;

    logic             clk = 1'b0;
    logic             r;
    logic             en;
    logic             rev;
    logic             load;
    logic             start;
    logic [1:0]       mode;
    logic [N-1:0]     lim;
    logic [N-1:0]     d;
    logic [N-1:0]     q;
    logic             tc;
    logic             at_lim;
    logic             busy;
`ifdef MOD_REV_CNT_PRESCALE_EN
    logic [PRE_W-1:0] pre_div;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mod_rev_cnt #(
        .N     (N),
        .PRE_W (PRE_W)
    ) dut (
        .clk     (clk),
        .R       (r),
        .en      (en),
        .rev     (rev),
        .load    (load),
        .start   (start),
        .mode    (mode),
        .lim     (lim),
        .D       (d),
`ifdef MOD_REV_CNT_PRESCALE_EN
        .pre_div (pre_div),
`endif
        .Q       (q),
        .tc      (tc),
        .at_lim  (at_lim),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int eq, input int etc, input int ebusy);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_tc"}, 32'(tc), 32'(etc));
        chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
    endtask

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sat_q [6];
        int sat_tc[6];
        sat_q  = '{4, 3, 2, 1, 0, 0};
        sat_tc = '{0, 0, 0, 0, 1, 0};

        r = 1'b1; en = 1'b0; rev = 1'b0; load = 1'b0; start = 1'b0;
        mode = 2'b00; lim = 4'd9; d = 4'd0;
`ifdef MOD_REV_CNT_PRESCALE_EN
        pre_div = '0;
`endif
        step();
        chk_out("reset", 0, 0, 0);
        r = 1'b0;

        // WRAP up through lim
        d = 4'd8; load = 1'b1; step(); chk_out("wrap_load", 8, 0, 0);
        load = 1'b0; en = 1'b1;
        step(); chk_out("wrap_9", 9, 0, 0); chk("wrap_at_lim", 32'(at_lim), 32'd1);
        step(); chk_out("wrap_0", 0, 1, 0);
        step(); chk_out("wrap_1", 1, 0, 0);

        // WRAP down from 0
        en = 1'b0; rev = 1'b1; d = 4'd0; load = 1'b1; step();
        load = 1'b0; en = 1'b1; step(); chk_out("wrap_dn", 9, 1, 0);
        rev = 1'b0;

        // load beats count
        d = 4'd7; load = 1'b1; step(); chk_out("load_pri", 7, 0, 0);
        load = 1'b0; en = 1'b0;

        // SAT clamp and count down
        mode = 2'b01; lim = 4'd5; d = 4'd12; load = 1'b1; step();
        chk_out("sat_clamp", 5, 0, 0); chk("sat_at_lim", 32'(at_lim), 32'd1);
        load = 1'b0; en = 1'b1; rev = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("sat_dn%0d_q", i), 32'(q), 32'(sat_q[i]));
            chk($sformatf("sat_dn%0d_tc", i), 32'(tc), 32'(sat_tc[i]));
        end
        rev = 1'b0; d = 4'd5; load = 1'b1; step();
        load = 1'b0; step(); chk_out("sat_hold", 5, 0, 0);
        en = 1'b0;

        // ONESHOT basic run
        mode = 2'b10; lim = 4'd3; d = 4'd1; start = 1'b1; en = 1'b1;
        step(); chk_out("os_start", 1, 0, 1);
        start = 1'b0;
        step(); chk_out("os_2", 2, 0, 1);
        step(); chk_out("os_done", 3, 1, 0);
        step(); chk_out("os_hold", 3, 0, 0);

        // reset during RUN overrides start and load
        en = 1'b0; d = 4'd0; start = 1'b1; step(); chk_out("os_rst_pre", 0, 0, 1);
        r = 1'b1; load = 1'b1; d = 4'd5; en = 1'b1; step(); chk_out("os_rst", 0, 0, 0);
        r = 1'b0; start = 1'b0; load = 1'b0; step(); chk_out("os_idle", 0, 0, 0);

        // direction flip mid-run ends at 0
        en = 1'b0; lim = 4'd9; d = 4'd3; start = 1'b1; step(); chk_out("os_rv_start", 3, 0, 1);
        start = 1'b0; en = 1'b1; step(); chk_out("os_rv_up", 4, 0, 1);
        rev = 1'b1;
        step(); step(); step(); chk_out("os_rv_1", 1, 0, 1);
        step(); chk_out("os_rv_done", 0, 1, 0);
        en = 1'b0; rev = 1'b0;

        // leaving ONESHOT returns to free counting
        d = 4'd2; start = 1'b1; step(); chk_out("os_leave_start", 2, 0, 1);
        start = 1'b0; mode = 2'b00; en = 1'b1; step(); chk_out("os_leave", 3, 0, 0);

        // lim = 0 in WRAP: tc every count
        en = 1'b0; lim = 4'd0; d = 4'd0; load = 1'b1; step();
        load = 1'b0; en = 1'b1;
        step(); chk_out("lim0_a", 0, 1, 0);
        step(); chk_out("lim0_b", 0, 1, 0);

        // limit lowered below Q
        en = 1'b0; mode = 2'b01; lim = 4'd9; d = 4'd8; load = 1'b1; step();
        load = 1'b0; lim = 4'd3; en = 1'b1;
        step(); chk_out("low_sat", 3, 1, 0);
        step(); chk_out("low_sat_hold", 3, 0, 0);
        en = 1'b0; mode = 2'b00; lim = 4'd9; load = 1'b1; step();
        load = 1'b0; lim = 4'd3; en = 1'b1;
        step(); chk_out("low_wrap", 0, 1, 0);
        en = 1'b0;

`ifdef MOD_REV_CNT_PRESCALE_EN
        begin
            int pq[6];
            pq = '{0, 0, 1, 1, 1, 2};
            lim = 4'd15; pre_div = 4'd2; d = 4'd0; load = 1'b1; step();
            load = 1'b0; en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                chk($sformatf("pre_%0d", i), 32'(q), 32'(pq[i]));
            end
            step();
            d = 4'd5; load = 1'b1; step(); chk("pre_load", 32'(q), 32'd5);
            load = 1'b0;
            step(); chk("pre_ph1", 32'(q), 32'd5);
            step(); chk("pre_ph2", 32'(q), 32'd5);
            step(); chk("pre_ph3", 32'(q), 32'd6);
            en = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
